square_game_sequencer: RTL and testbench
========================================

Name: square_game_sequencer

Overview:
- Sequences the square game datapath: requests a square location from the picker, then drives the square drawer to paint the square white.
- Holds the square on screen for a timeout window and checks mouse clicks for hits.
- Drives the drawer again to erase the square (black), then repeats.
- Owns the framebuffer write port: muxes drawer pixels onto it with the correct colour, issues score pulses and ends the game after too many misses.

Parameters:
- COORD_W, 11, width of all x/y coordinates.
- SQ_SIZE, 20, square edge length in pixels; must match the drawer.
- TIMEOUT, 50000000, cycles the square stays visible before a miss; at least 2.
- MAX_MISSES, 3, misses that end the game; at least 1.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  level; game enable
- mouse_click  in  1  level; left button, already synchronous to clk
- mouse_x, mouse_y  in  COORD_W  cursor position
- pick_req  out  1  one-cycle pulse; picker advances to a new location
- loc_x, loc_y  in  COORD_W  picker location; valid from the cycle after pick_req
- drw_start  out  1  one-cycle pulse; starts the drawer
- drw_x0, drw_y0  out  COORD_W  square origin to the drawer
- drw_done  in  1  drawer finished (pulse or level)
- drw_x, drw_y  in  COORD_W  drawer pixel coordinates
- fb_x, fb_y  out  COORD_W  framebuffer pixel address
- fb_color  out  1  1 = white, 0 = black
- fb_write  out  1  framebuffer write enable
- point  out  1  one-cycle pulse per hit, to the score block
- game_over  out  1  level; set when the miss limit is reached

Behaviour:
- Reset: state IDLE. Timer, miss count, sq_x, sq_y and click history all 0. All outputs 0.
- Reset asserted mid-draw: drop to IDLE next cycle and stop writing; the partially drawn square is left in the framebuffer.
- IDLE: when start=1, go to PICK.
- PICK: pick_req=1 for this one cycle; next state LATCH.
- LATCH: capture loc_x/loc_y into sq_x/sq_y. Assert drw_start=1 with drw_x0/drw_y0 = loc (same cycle); color register = 1. Next state DRAW.
- DRAW and ERASE:
  - fb_write=1; fb_x/fb_y follow drw_x/drw_y combinationally (zero added latency); fb_color = color register.
  - drw_x0/drw_y0 hold sq_x/sq_y throughout.
  - drw_done=1 in DRAW: clear timer, go to SHOW.
- SHOW:
  - fb_write=0; timer increments every cycle.
  - Hit = rising edge of mouse_click (history register) AND sq_x <= mouse_x <= sq_x+SQ_SIZE-1 AND the same test on y. Compare at COORD_W+1 bits so the upper bound cannot wrap.
  - Hit: point=1 for that cycle; go to ERASE.
  - Else if timer == TIMEOUT-1: miss count +1; go to ERASE.
  - Else if start=0: go to ERASE, flagged to return to IDLE.
  - Priority: hit > timeout > start low. A hit on the final timeout cycle scores and does not count as a miss.
- Entering ERASE: drw_start=1 pulse, color = 0, same sq_x/sq_y.
- ERASE exit on drw_done:
  - Miss count == MAX_MISSES: go to OVER.
  - Else if the abort flag is set: clear it, go to IDLE.
  - Else: go to PICK.
- OVER: game_over=1, no writes, ignore all inputs until reset.
- Clicks outside SHOW are ignored. A button held from an earlier state produces no edge.
- Miss count saturates at MAX_MISSES.
- Timer width: clog2(TIMEOUT).
- Registered outputs: drw_start, pick_req, point, game_over. fb_* are combinational, decoded from the state register.

Decomposition:
- Package square_game_pkg holds:
  - enum state_t {IDLE, PICK, LATCH, DRAW, SHOW, ERASE, OVER};
  - localparam COLOR_WHITE=1, COLOR_BLACK=0;
  - default COORD_W.
- Sub-module square_hit_detector:
  - Contains click edge detect plus inclusive bounds compare.
  - Inputs: clk, reset, en, mouse_click, mouse_x, mouse_y, sq_x, sq_y.
  - Output: hit, one cycle.

Test Plan (TIMEOUT=8, SQ_SIZE=4, MAX_MISSES=2, drawer model asserts done 16 cycles after start):
- Reset held 2 cycles, then start=1 -> cycle 1 pick_req=1; cycle 2 drw_start=1 with x0,y0 = loc (e.g. 100,50); fb_write=1 and fb_color=1 for the 16 draw cycles.
- In SHOW, click rising at mouse (103,53) -> point=1 exactly one cycle; ERASE starts with fb_color=0 and x0,y0=100,50; miss count stays 0.
- Clicks at (104,50) and (99,53) -> no point; after 8 SHOW cycles miss=1, ERASE, then pick_req again.
- Second timeout -> after erase done, game_over=1 stays high; further clicks and start toggles cause no writes and no point until reset.
- Click edge on the exact cycle timer==7, inside the square -> point=1, miss count unchanged.
- Square at (2046,2046), mouse (2047,2047) click -> hit (no wrap). Reset asserted during DRAW -> next cycle fb_write=0, state IDLE, all outputs 0.

Source files
------------

// File: rtl/square_game_pkg.sv
// Shared types and constants for the square game sequencer and its helpers.
package square_game_pkg;

    // Default coordinate width used by the sequencer and hit detector.
    localparam int COORD_W_DEFAULT = 11;

    // Framebuffer colour encodings.
    localparam logic COLOR_WHITE = 1'b1;
    localparam logic COLOR_BLACK = 1'b0;

    // Sequencer states.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PICK  = 3'd1,
        LATCH = 3'd2,
        DRAW  = 3'd3,
        SHOW  = 3'd4,
        ERASE = 3'd5,
        OVER  = 3'd6
    } state_t;

endpackage

// File: rtl/square_hit_detector.sv
// Detects a left-button press landing inside the currently shown square.
// The press is a rising edge of the button level; the bounds test is
// inclusive on both ends and done one bit wider than the coordinates so a
// square near the right/bottom edge of the coordinate space cannot wrap.
module square_hit_detector
    import square_game_pkg::*;
#(
    parameter int COORD_W = COORD_W_DEFAULT,
    parameter int SQ_SIZE = 20
)(
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    input  logic               mouse_click,
    input  logic [COORD_W-1:0] mouse_x,
    input  logic [COORD_W-1:0] mouse_y,
    input  logic [COORD_W-1:0] sq_x,
    input  logic [COORD_W-1:0] sq_y,
    output logic               hit
);

    localparam logic [COORD_W:0] SPAN = (COORD_W+1)'(SQ_SIZE - 1);

    logic             click_prev_r;
    logic             click_rise_s;
    logic [COORD_W:0] mx_s;
    logic [COORD_W:0] my_s;
    logic [COORD_W:0] lo_x_s;
    logic [COORD_W:0] lo_y_s;
    logic [COORD_W:0] hi_x_s;
    logic [COORD_W:0] hi_y_s;
    logic             in_x_s;
    logic             in_y_s;

    // Button history; tracked every cycle so a button held from an earlier state never looks like a press.
    always_ff @(posedge clk) begin
        if (reset) begin
            click_prev_r <= 1'b0;
        end else begin
            click_prev_r <= mouse_click;
        end
    end

    // Press edge and widened inclusive bounds compare.
    always_comb begin
        mx_s         = {1'b0, mouse_x};
        my_s         = {1'b0, mouse_y};
        lo_x_s       = {1'b0, sq_x};
        lo_y_s       = {1'b0, sq_y};
        hi_x_s       = lo_x_s + SPAN;
        hi_y_s       = lo_y_s + SPAN;
        in_x_s       = (mx_s >= lo_x_s) && (mx_s <= hi_x_s);
        in_y_s       = (my_s >= lo_y_s) && (my_s <= hi_y_s);
        click_rise_s = mouse_click & ~click_prev_r;
        hit          = en & click_rise_s & in_x_s & in_y_s;
    end

endmodule

// File: rtl/square_game_sequencer.sv
// Square game sequencer: picks a location, paints the square white, waits
// for a hit or a timeout, paints it black again and repeats until the miss
// limit ends the game. Owns the framebuffer write port.
module square_game_sequencer
    import square_game_pkg::*;
#(
    parameter int COORD_W    = COORD_W_DEFAULT,
    parameter int SQ_SIZE    = 20,
    parameter int TIMEOUT    = 50000000,
    parameter int MAX_MISSES = 3
)(
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               mouse_click,
    input  logic [COORD_W-1:0] mouse_x,
    input  logic [COORD_W-1:0] mouse_y,
    output logic               pick_req,
    input  logic [COORD_W-1:0] loc_x,
    input  logic [COORD_W-1:0] loc_y,
    output logic               drw_start,
    output logic [COORD_W-1:0] drw_x0,
    output logic [COORD_W-1:0] drw_y0,
    input  logic               drw_done,
    input  logic [COORD_W-1:0] drw_x,
    input  logic [COORD_W-1:0] drw_y,
    output logic [COORD_W-1:0] fb_x,
    output logic [COORD_W-1:0] fb_y,
    output logic               fb_color,
    output logic               fb_write,
    output logic               point,
    output logic               game_over
);

    localparam int TIMER_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int MISS_W  = $clog2(MAX_MISSES + 1);

    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT - 1);
    localparam logic [MISS_W-1:0]  MISS_LIMIT = MISS_W'(MAX_MISSES);

    state_t               state_r;
    state_t               state_nxt_s;
    logic [TIMER_W-1:0]   timer_r;
    logic [MISS_W-1:0]    miss_cnt_r;
    logic [COORD_W-1:0]   sq_x_r;
    logic [COORD_W-1:0]   sq_y_r;
    logic                 color_r;
    logic                 abort_r;
    logic                 pick_req_r;
    logic                 drw_start_r;
    logic                 point_r;
    logic                 game_over_r;

    logic                 hit_s;
    logic                 show_s;
    logic                 timeout_s;
    logic                 erase_done_s;
    logic                 enter_erase_s;
    logic                 drawing_s;

    assign show_s    = (state_r == SHOW);
    assign timeout_s = (timer_r == TIMER_LAST);

    // The erase start pulse coincides with the first ERASE cycle; a level-style
    // done still high from the previous pass must not end the erase early.
    assign erase_done_s  = drw_done & ~drw_start_r;
    assign enter_erase_s = show_s && (state_nxt_s == ERASE);
    assign drawing_s     = (state_r == DRAW) || (state_r == ERASE);

    square_hit_detector #(
        .COORD_W (COORD_W),
        .SQ_SIZE (SQ_SIZE)
    ) u_hit (
        .clk         (clk),
        .reset       (reset),
        .en          (show_s),
        .mouse_click (mouse_click),
        .mouse_x     (mouse_x),
        .mouse_y     (mouse_y),
        .sq_x        (sq_x_r),
        .sq_y        (sq_y_r),
        .hit         (hit_s)
    );

    // Next-state decode; in SHOW a hit beats a timeout, which beats start going low.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_nxt_s = PICK;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            PICK:  state_nxt_s = LATCH;
            LATCH: state_nxt_s = DRAW;
            DRAW: begin
                if (drw_done) begin
                    state_nxt_s = SHOW;
                end else begin
                    state_nxt_s = DRAW;
                end
            end
            SHOW: begin
                if (hit_s) begin
                    state_nxt_s = ERASE;
                end else if (timeout_s) begin
                    state_nxt_s = ERASE;
                end else if (!start) begin
                    state_nxt_s = ERASE;
                end else begin
                    state_nxt_s = SHOW;
                end
            end
            ERASE: begin
                if (erase_done_s) begin
                    if (miss_cnt_r == MISS_LIMIT) begin
                        state_nxt_s = OVER;
                    end else if (abort_r) begin
                        state_nxt_s = IDLE;
                    end else begin
                        state_nxt_s = PICK;
                    end
                end else begin
                    state_nxt_s = ERASE;
                end
            end
            OVER:    state_nxt_s = OVER;
            default: state_nxt_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Visibility timer: cleared when the square finishes drawing, counts while shown.
    always_ff @(posedge clk) begin
        if (reset) begin
            timer_r <= '0;
        end else if ((state_r == DRAW) && drw_done) begin
            timer_r <= '0;
        end else if (show_s) begin
            timer_r <= timer_r + TIMER_W'(1);
        end else begin
            timer_r <= timer_r;
        end
    end

    // Miss counter (timeouts without a hit), saturating at the limit.
    always_ff @(posedge clk) begin
        if (reset) begin
            miss_cnt_r <= '0;
        end else if (show_s && !hit_s && timeout_s && (miss_cnt_r < MISS_LIMIT)) begin
            miss_cnt_r <= miss_cnt_r + MISS_W'(1);
        end else begin
            miss_cnt_r <= miss_cnt_r;
        end
    end

    // Abort flag: start dropped while showing, so the erase returns to IDLE.
    always_ff @(posedge clk) begin
        if (reset) begin
            abort_r <= 1'b0;
        end else if (show_s && !hit_s && !timeout_s && !start) begin
            abort_r <= 1'b1;
        end else if ((state_r == ERASE) && erase_done_s) begin
            abort_r <= 1'b0;
        end else begin
            abort_r <= abort_r;
        end
    end

    // Square origin and paint colour for the current pass.
    always_ff @(posedge clk) begin
        if (reset) begin
            sq_x_r  <= '0;
            sq_y_r  <= '0;
            color_r <= COLOR_BLACK;
        end else if (state_r == LATCH) begin
            sq_x_r  <= loc_x;
            sq_y_r  <= loc_y;
            color_r <= COLOR_WHITE;
        end else if (enter_erase_s) begin
            sq_x_r  <= sq_x_r;
            sq_y_r  <= sq_y_r;
            color_r <= COLOR_BLACK;
        end else begin
            sq_x_r  <= sq_x_r;
            sq_y_r  <= sq_y_r;
            color_r <= color_r;
        end
    end

    // Registered control pulses and game-over level, aligned with the state they belong to.
    always_ff @(posedge clk) begin
        if (reset) begin
            pick_req_r  <= 1'b0;
            drw_start_r <= 1'b0;
            point_r     <= 1'b0;
            game_over_r <= 1'b0;
        end else begin
            pick_req_r  <= (state_nxt_s == PICK);
            drw_start_r <= (state_nxt_s == LATCH) || enter_erase_s;
            point_r     <= show_s && hit_s;
            game_over_r <= (state_nxt_s == OVER);
        end
    end

    assign pick_req  = pick_req_r;
    assign drw_start = drw_start_r;
    assign point     = point_r;
    assign game_over = game_over_r;

    // Framebuffer port and drawer origin, decoded from the state register.
    always_comb begin
        if (drawing_s) begin
            fb_write = 1'b1;
            fb_x     = drw_x;
            fb_y     = drw_y;
            fb_color = color_r;
        end else begin
            fb_write = 1'b0;
            fb_x     = '0;
            fb_y     = '0;
            fb_color = COLOR_BLACK;
        end
        if (state_r == LATCH) begin
            drw_x0 = loc_x;
            drw_y0 = loc_y;
        end else begin
            drw_x0 = sq_x_r;
            drw_y0 = sq_y_r;
        end
    end

endmodule

// File: tb/tb_square_game_sequencer.sv
// Directed bench for square_game_sequencer with a small drawer model that
// walks a 4x4 square and reports done 16 cycles after its start pulse.
module tb_square_game_sequencer;

    localparam int CW = 11;

    logic          clk;
    logic          reset;
    logic          start;
    logic          mouse_click;
    logic [CW-1:0] mouse_x;
    logic [CW-1:0] mouse_y;
    logic          pick_req;
    logic [CW-1:0] loc_x;
    logic [CW-1:0] loc_y;
    logic          drw_start;
    logic [CW-1:0] drw_x0;
    logic [CW-1:0] drw_y0;
    logic          drw_done;
    logic [CW-1:0] drw_x;
    logic [CW-1:0] drw_y;
    logic [CW-1:0] fb_x;
    logic [CW-1:0] fb_y;
    logic          fb_color;
    logic          fb_write;
    logic          point;
    logic          game_over;

    int n_checks = 0;
    int n_fail   = 0;

    square_game_sequencer #(
        .COORD_W    (CW),
        .SQ_SIZE    (4),
        .TIMEOUT    (8),
        .MAX_MISSES (2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .mouse_click (mouse_click),
        .mouse_x     (mouse_x),
        .mouse_y     (mouse_y),
        .pick_req    (pick_req),
        .loc_x       (loc_x),
        .loc_y       (loc_y),
        .drw_start   (drw_start),
        .drw_x0      (drw_x0),
        .drw_y0      (drw_y0),
        .drw_done    (drw_done),
        .drw_x       (drw_x),
        .drw_y       (drw_y),
        .fb_x        (fb_x),
        .fb_y        (fb_y),
        .fb_color    (fb_color),
        .fb_write    (fb_write),
        .point       (point),
        .game_over   (game_over)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drawer model: 16 pixels row by row, done on the last one.
    logic          mdl_busy_r;
    logic [3:0]    mdl_cnt_r;
    logic [CW-1:0] mdl_x0_r;
    logic [CW-1:0] mdl_y0_r;

    always @(posedge clk) begin
        if (reset) begin
            mdl_busy_r <= 1'b0;
            mdl_cnt_r  <= 4'd0;
            mdl_x0_r   <= '0;
            mdl_y0_r   <= '0;
        end else if (drw_start) begin
            mdl_busy_r <= 1'b1;
            mdl_cnt_r  <= 4'd0;
            mdl_x0_r   <= drw_x0;
            mdl_y0_r   <= drw_y0;
        end else if (mdl_busy_r) begin
            if (mdl_cnt_r == 4'd15) mdl_busy_r <= 1'b0;
            mdl_cnt_r <= mdl_cnt_r + 4'd1;
        end
    end

    assign drw_done = mdl_busy_r && (mdl_cnt_r == 4'd15);
    assign drw_x    = mdl_x0_r + {9'd0, mdl_cnt_r[1:0]};
    assign drw_y    = mdl_y0_r + {9'd0, mdl_cnt_r[3:2]};

    task automatic check_value(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Wait (bounded) for pick_req (which=0) or game_over (which=1).
    task automatic wait_sig(input int which, input int budget, input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (which == 0) seen = pick_req;
            else            seen = game_over;
        end
        check_value(tag, 32'(seen), 32'd1);
    endtask

    // From a PICK cycle: LATCH, 16 DRAW cycles, then first SHOW cycle.
    task automatic draw_to_show(input string tag);
        tick(18);
        check_value(tag, 32'(fb_write), 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check_value({tag, "_outs"}, 32'({pick_req, drw_start, point, game_over, fb_write, fb_color}), 32'd0);
        check_value({tag, "_addr"}, 32'({fb_x, fb_y, drw_x0, drw_y0}), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int errs;
        int act;
        reset = 1'b1; start = 1'b0; mouse_click = 1'b0;
        mouse_x = '0; mouse_y = '0; loc_x = '0; loc_y = '0;
        tick(2);
        check_all_zero("reset");

        // Round 1: draw at (100,50), hit at (103,53).
        reset = 1'b0; start = 1'b1; loc_x = 11'd100; loc_y = 11'd50;
        tick(1);
        check_value("pick_pulse", 32'(pick_req), 32'd1);
        tick(1);
        check_value("latch_start", 32'(drw_start), 32'd1);
        check_value("latch_x0", 32'(drw_x0), 32'd100);
        check_value("latch_y0", 32'(drw_y0), 32'd50);
        check_value("latch_pick_low", 32'(pick_req), 32'd0);
        errs = 0;
        for (int k = 0; k < 16; k++) begin
            tick(1);
            if (fb_write !== 1'b1 || fb_color !== 1'b1 ||
                fb_x !== 11'(100 + k % 4) || fb_y !== 11'(50 + k / 4)) errs++;
        end
        check_value("draw_pixels", 32'(errs), 32'd0);
        tick(1);
        check_value("show_no_write", 32'(fb_write), 32'd0);
        mouse_x = 11'd103; mouse_y = 11'd53; mouse_click = 1'b1;
        tick(1);
        check_value("hit_point", 32'(point), 32'd1);
        check_value("erase_start", 32'(drw_start), 32'd1);
        check_value("erase_color", 32'(fb_color), 32'd0);
        check_value("erase_write", 32'(fb_write), 32'd1);
        check_value("erase_x0", 32'(drw_x0), 32'd100);
        check_value("erase_y0", 32'(drw_y0), 32'd50);
        mouse_click = 1'b0;
        tick(1);
        check_value("point_one_cycle", 32'(point), 32'd0);
        wait_sig(0, 40, "erase_to_pick");

        // Round 2: near-miss clicks, then timeout (miss 1).
        draw_to_show("show2_no_write");
        mouse_x = 11'd104; mouse_y = 11'd50; mouse_click = 1'b1;
        tick(1);
        check_value("miss_right_edge", 32'(point), 32'd0);
        mouse_click = 1'b0;
        tick(1);
        mouse_x = 11'd99; mouse_y = 11'd53; mouse_click = 1'b1;
        tick(1);
        check_value("miss_left_edge", 32'(point), 32'd0);
        mouse_click = 1'b0;
        tick(4);
        check_value("show_hold_t7", 32'(fb_write), 32'd0);
        tick(1);
        check_value("timeout_erase", 32'(drw_start), 32'd1);
        check_value("timeout_no_point", 32'(point), 32'd0);
        wait_sig(0, 40, "pick_after_miss");
        check_value("not_over_yet", 32'(game_over), 32'd0);

        // Round 3: second timeout ends the game.
        draw_to_show("show3_no_write");
        tick(8);
        wait_sig(1, 40, "game_over_set");
        act = 0;
        for (int i = 0; i < 20; i++) begin
            start = i[0]; mouse_click = i[1];
            mouse_x = 11'd101; mouse_y = 11'd51;
            tick(1);
            if (fb_write || point || pick_req || drw_start) act++;
        end
        check_value("over_idle_activity", 32'(act), 32'd0);
        check_value("over_holds", 32'(game_over), 32'd1);

        // Round 4: hit on the last timeout cycle, then one miss, then abort.
        reset = 1'b1; start = 1'b1; mouse_click = 1'b0;
        tick(2);
        check_all_zero("reset2");
        reset = 1'b0; loc_x = 11'd100; loc_y = 11'd50;
        wait_sig(0, 4, "restart_pick");
        draw_to_show("show4_no_write");
        tick(7);
        mouse_x = 11'd100; mouse_y = 11'd50; mouse_click = 1'b1;
        tick(1);
        check_value("hit_on_timeout", 32'(point), 32'd1);
        mouse_click = 1'b0;
        wait_sig(0, 40, "pick_after_late_hit");
        draw_to_show("show5_no_write");
        tick(8);
        wait_sig(0, 40, "pick_after_one_miss");
        check_value("late_hit_not_miss", 32'(game_over), 32'd0);
        draw_to_show("show6_no_write");
        start = 1'b0;
        tick(1);
        check_value("abort_erase", 32'(drw_start), 32'd1);
        act = 0;
        for (int i = 0; i < 25; i++) begin
            tick(1);
            if (pick_req) act++;
        end
        check_value("abort_no_pick", 32'(act), 32'd0);
        check_value("abort_idle_write", 32'(fb_write), 32'd0);
        check_value("abort_not_over", 32'(game_over), 32'd0);
        start = 1'b1;
        tick(1);
        check_value("restart_after_abort", 32'(pick_req), 32'd1);

        // Round 5: square at the coordinate limit, then reset mid-draw.
        reset = 1'b1;
        tick(2);
        reset = 1'b0; loc_x = 11'd2046; loc_y = 11'd2046;
        wait_sig(0, 4, "pick_wrap");
        draw_to_show("show7_no_write");
        mouse_x = 11'd2047; mouse_y = 11'd2047; mouse_click = 1'b1;
        tick(1);
        check_value("hit_no_wrap", 32'(point), 32'd1);
        mouse_click = 1'b0;
        wait_sig(0, 40, "pick_after_wrap_hit");
        tick(4);
        check_value("mid_draw_write", 32'(fb_write), 32'd1);
        reset = 1'b1;
        tick(1);
        check_all_zero("reset_mid_draw");
        reset = 1'b0; start = 1'b0;
        tick(3);
        check_value("idle_after_reset", 32'({pick_req, fb_write}), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
